// File: rtl/line_window_pkg.sv
// Shared constants for the median-filter front end: default image geometry
// and the 3x3 window indices also used by the downstream median stage.
package line_window_pkg;

    localparam int DEF_IMG_WIDTH  = 640;
    localparam int DEF_IMG_HEIGHT = 480;
    localparam int DEF_DATA_W     = 8;

    // Window rows: top is line r-2, bottom is the line currently streaming in.
    localparam int ROW_TOP = 0;
    localparam int ROW_MID = 1;
    localparam int ROW_BOT = 2;

    // Window columns: right holds the newest column.
    localparam int COL_L = 0;
    localparam int COL_C = 1;
    localparam int COL_R = 2;

endpackage

// File: rtl/line_window_3x3_line_buf.sv
// One line of pixel history: asynchronous read, synchronous write,
// read-before-write at the same address.
module line_buf #(
    parameter int DEPTH  = 640,
    parameter int DATA_W = 8,
    localparam int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] mem [DEPTH];

    // The read returns the old contents during the write cycle.
    assign rd_data = mem[addr];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[addr] <= wr_data;
        end
    end

endmodule

// File: rtl/line_window_3x3.sv
// Raster stream to 3x3 neighbourhood generator with two line buffers.
// Optional macro LINE_WINDOW_SOF_ERR_EN adds the sticky err_short_frame output.
module line_window_3x3
    import line_window_pkg::*;
#(
    parameter int IMG_WIDTH  = DEF_IMG_WIDTH,
    parameter int IMG_HEIGHT = DEF_IMG_HEIGHT,
    parameter int DATA_W     = DEF_DATA_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              pix_valid,
    input  logic [DATA_W-1:0] pix_data,
    input  logic              sof,
    output logic              win_valid,
    output logic              win_last,
    output logic [DATA_W-1:0] m11,
    output logic [DATA_W-1:0] m12,
    output logic [DATA_W-1:0] m13,
    output logic [DATA_W-1:0] m21,
    output logic [DATA_W-1:0] m22,
    output logic [DATA_W-1:0] m23,
    output logic [DATA_W-1:0] m31,
    output logic [DATA_W-1:0] m32,
    output logic [DATA_W-1:0] m33
`ifdef LINE_WINDOW_SOF_ERR_EN
    ,
    output logic              err_short_frame
`endif
);

    localparam int COL_W = $clog2(IMG_WIDTH);
    localparam int ROW_W = $clog2(IMG_HEIGHT);
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_WIDTH - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_HEIGHT - 1);
    localparam logic [COL_W-1:0] COL_FIRST_WIN = COL_W'(2);
    localparam logic [ROW_W-1:0] ROW_FIRST_WIN = ROW_W'(2);

    logic [COL_W-1:0]  col;
    logic [ROW_W-1:0]  row;
    logic [COL_W-1:0]  cur_col;
    logic [ROW_W-1:0]  cur_row;
    logic              wr_en;
    logic [DATA_W-1:0] tap_top;
    logic [DATA_W-1:0] tap_mid;
    logic [DATA_W-1:0] win [3][3];

    // sof re-labels the pixel being accepted as (0,0), mid-frame included.
    always_comb begin
        cur_col = col;
        cur_row = row;
        if (sof) begin
            cur_col = '0;
            cur_row = '0;
        end
    end

    assign wr_en = pix_valid & rst_n;

    line_buf #(
        .DEPTH  (IMG_WIDTH),
        .DATA_W (DATA_W)
    ) u_lb1 (
        .clk     (clk),
        .wr_en   (wr_en),
        .addr    (cur_col),
        .wr_data (pix_data),
        .rd_data (tap_mid)
    );

    // lb2 ages the line leaving lb1, so it always holds line r-2.
    line_buf #(
        .DEPTH  (IMG_WIDTH),
        .DATA_W (DATA_W)
    ) u_lb2 (
        .clk     (clk),
        .wr_en   (wr_en),
        .addr    (cur_col),
        .wr_data (tap_mid),
        .rd_data (tap_top)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            col <= '0;
            row <= '0;
        end else if (pix_valid) begin
            if (cur_col == COL_LAST) begin
                col <= '0;
                row <= (cur_row == ROW_LAST) ? '0 : cur_row + 1'b1;
            end else begin
                col <= cur_col + 1'b1;
                row <= cur_row;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int r = 0; r < 3; r++) begin
                for (int c = 0; c < 3; c++) begin
                    win[r][c] <= '0;
                end
            end
        end else if (pix_valid) begin
            for (int r = 0; r < 3; r++) begin
                win[r][COL_L] <= win[r][COL_C];
                win[r][COL_C] <= win[r][COL_R];
            end
            win[ROW_TOP][COL_R] <= tap_top;
            win[ROW_MID][COL_R] <= tap_mid;
            win[ROW_BOT][COL_R] <= pix_data;
        end
    end

    // Only windows made entirely of the current frame's pixels are flagged.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            win_valid <= 1'b0;
            win_last  <= 1'b0;
        end else begin
            win_valid <= pix_valid && (cur_row >= ROW_FIRST_WIN) && (cur_col >= COL_FIRST_WIN);
            win_last  <= pix_valid && (cur_row == ROW_LAST) && (cur_col == COL_LAST);
        end
    end

`ifdef LINE_WINDOW_SOF_ERR_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            err_short_frame <= 1'b0;
        end else if (pix_valid && sof && ((row != '0) || (col != '0))) begin
            err_short_frame <= 1'b1;
        end
    end
`else
    // Without error tracking a mid-frame sof simply resynchronises the counters.
`endif

    assign m11 = win[ROW_TOP][COL_L];
    assign m12 = win[ROW_TOP][COL_C];
    assign m13 = win[ROW_TOP][COL_R];
    assign m21 = win[ROW_MID][COL_L];
    assign m22 = win[ROW_MID][COL_C];
    assign m23 = win[ROW_MID][COL_R];
    assign m31 = win[ROW_BOT][COL_L];
    assign m32 = win[ROW_BOT][COL_C];
    assign m33 = win[ROW_BOT][COL_R];

endmodule

// File: tb/tb_line_window_3x3.sv
// Self-checking bench for line_window_3x3 on a 5x4 image, using a frame-array
// reference model indexed by (row, col).
module tb_line_window_3x3;

    localparam int W  = 5;
    localparam int H  = 4;
    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          pix_valid = 1'b0;
    logic          sof = 1'b0;
    logic [DW-1:0] pix_data = '0;
    logic          win_valid;
    logic          win_last;
    logic [DW-1:0] m11, m12, m13, m21, m22, m23, m31, m32, m33;
`ifdef LINE_WINDOW_SOF_ERR_EN
    logic          err_short_frame;
`endif
    logic [71:0]   dut_win;

    int checks = 0;
    int errors = 0;

    // Reference model: current-frame pixel array plus raster position.
    logic [DW-1:0] img [H][W];
    int            mrow = 0;
    int            mcol = 0;
    logic          exp_valid = 1'b0;
    logic          exp_last = 1'b0;
    logic [71:0]   exp_win = '0;
    bit            exp_known = 1'b0;
    int            win_count = 0;
    int            dut_count = 0;

    line_window_3x3 #(
        .IMG_WIDTH  (W),
        .IMG_HEIGHT (H),
        .DATA_W     (DW)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .pix_valid (pix_valid),
        .pix_data  (pix_data),
        .sof       (sof),
        .win_valid (win_valid),
        .win_last  (win_last),
        .m11 (m11), .m12 (m12), .m13 (m13),
        .m21 (m21), .m22 (m22), .m23 (m23),
        .m31 (m31), .m32 (m32), .m33 (m33)
`ifdef LINE_WINDOW_SOF_ERR_EN
        ,
        .err_short_frame (err_short_frame)
`endif
    );

    assign dut_win = {m11, m12, m13, m21, m22, m23, m31, m32, m33};

    always #5 clk = ~clk;

    task automatic model_reset();
        mrow      = 0;
        mcol      = 0;
        exp_valid = 1'b0;
        exp_last  = 1'b0;
        exp_win   = '0;
        exp_known = 1'b1;
    endtask

    task automatic model_accept(input logic [DW-1:0] d, input logic s);
        if (s) begin
            mrow = 0;
            mcol = 0;
        end
        img[mrow][mcol] = d;
        exp_valid = (mrow >= 2) && (mcol >= 2);
        exp_last  = (mrow == H - 1) && (mcol == W - 1);
        if (exp_valid) begin
            for (int r = 0; r < 3; r++)
                for (int c = 0; c < 3; c++)
                    exp_win[71 - 8 * (r * 3 + c) -: 8] = img[mrow - 2 + r][mcol - 2 + c];
            exp_known = 1'b1;
            win_count++;
        end else begin
            exp_known = 1'b0;
        end
        mcol++;
        if (mcol == W) begin
            mcol = 0;
            mrow = (mrow + 1) % H;
        end
    endtask

    // Drive one cycle, then step the model; outputs are examined 1 ns after the edge.
    task automatic applyStimulus(input logic v, input logic [DW-1:0] d, input logic s);
        pix_valid = v;
        pix_data  = d;
        sof       = s;
        @(posedge clk);
        #1;
        if (v) begin
            model_accept(d, s);
        end else begin
            exp_valid = 1'b0;
            exp_last  = 1'b0;
        end
        if (win_valid === 1'b1) dut_count++;
    endtask

    task automatic applyReset(input int n);
        rst_n = 1'b0;
        repeat (n) begin
            pix_valid = 1'($urandom);
            pix_data  = DW'($urandom);
            sof       = 1'($urandom);
            @(posedge clk);
            #1;
        end
        model_reset();
        rst_n     = 1'b1;
        pix_valid = 1'b0;
        sof       = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        for (int i = 0; i < 2; i++) begin
            pix_valid = 1'($urandom);
            pix_data  = DW'($urandom);
            sof       = 1'($urandom);
            @(posedge clk);
            #1;
            checks++;
            if (win_valid !== 1'b0 || win_last !== 1'b0 || dut_win !== 72'h0) begin
                errors++;
                $display("[TB] FAIL reset cycle %0d: got valid=%b last=%b win=%h, want 0 0 0",
                         i, win_valid, win_last, dut_win);
            end
        end
        model_reset();
        rst_n     = 1'b1;
        pix_valid = 1'b0;
        sof       = 1'b0;
    endtask

    task automatic test_continuous();
        win_count = 0;
        dut_count = 0;
        for (int i = 0; i < W * H; i++) begin
            logic [DW-1:0] d;
            d = DW'(((i / W) * 16) + (i % W));
            applyStimulus(1'b1, d, i == 0);
            checks++;
            if (win_valid !== exp_valid || win_last !== exp_last) begin
                errors++;
                $display("[TB] FAIL continuous flags pix %h: got valid=%b last=%b, want %b %b",
                         d, win_valid, win_last, exp_valid, exp_last);
            end
            if (exp_known) begin
                checks++;
                if (dut_win !== exp_win) begin
                    errors++;
                    $display("[TB] FAIL continuous window pix %h: got %h want %h", d, dut_win, exp_win);
                end
            end
            if (exp_valid && win_count == 1) begin
                checks++;
                if (dut_win !== 72'h00_01_02_10_11_12_20_21_22) begin
                    errors++;
                    $display("[TB] FAIL continuous first window: got %h want 000102101112202122", dut_win);
                end
            end
            if (i == W * H - 1) begin
                checks++;
                if (m33 !== 8'h34 || win_last !== 1'b1) begin
                    errors++;
                    $display("[TB] FAIL continuous last window: got m33=%h last=%b want 34 1", m33, win_last);
                end
            end
        end
        checks++;
        if (dut_count !== 6) begin
            errors++;
            $display("[TB] FAIL continuous window count: got %0d want 6", dut_count);
        end
    endtask

    task automatic test_gapped();
        int k = 0;
        int n = 0;
        win_count = 0;
        dut_count = 0;
        while (n < W * H) begin
            logic v;
            logic [DW-1:0] d;
            v = (k % 4 == 0) || (k % 4 == 3);
            d = DW'(((n / W) * 16) + (n % W));
            applyStimulus(v, v ? d : DW'($urandom), v && n == 0);
            if (v) n++;
            k++;
            checks++;
            if (win_valid !== exp_valid || win_last !== exp_last) begin
                errors++;
                $display("[TB] FAIL gapped flags cycle %0d: got valid=%b last=%b, want %b %b",
                         k, win_valid, win_last, exp_valid, exp_last);
            end
            if (exp_known) begin
                checks++;
                if (dut_win !== exp_win) begin
                    errors++;
                    $display("[TB] FAIL gapped window cycle %0d: got %h want %h", k, dut_win, exp_win);
                end
            end
        end
        checks++;
        if (dut_count !== 6) begin
            errors++;
            $display("[TB] FAIL gapped window count: got %0d want 6", dut_count);
        end
    endtask

    task automatic test_random();
        int n = 0;
        int k = 0;
        win_count = 0;
        dut_count = 0;
        while (n < 2 * W * H) begin
            logic v;
            logic [DW-1:0] d;
            v = ($urandom_range(0, 3) != 0);
            d = DW'($urandom);
            applyStimulus(v, d, v && (n % (W * H) == 0));
            if (v) n++;
            k++;
            checks++;
            if (win_valid !== exp_valid || win_last !== exp_last) begin
                errors++;
                $display("[TB] FAIL random flags cycle %0d: got valid=%b last=%b, want %b %b",
                         k, win_valid, win_last, exp_valid, exp_last);
            end
            if (exp_known) begin
                checks++;
                if (dut_win !== exp_win) begin
                    errors++;
                    $display("[TB] FAIL random window cycle %0d: got %h want %h", k, dut_win, exp_win);
                end
            end
        end
        checks++;
        if (dut_count !== 12) begin
            errors++;
            $display("[TB] FAIL random window count: got %0d want 12", dut_count);
        end
    endtask

    task automatic test_sof_resync();
        for (int i = 0; i < 8; i++)
            applyStimulus(1'b1, DW'(((i / W) * 16) + (i % W)), i == 0);
        win_count = 0;
        dut_count = 0;
        for (int i = 0; i < W * H; i++) begin
            logic [DW-1:0] d;
            d = (i == 0) ? 8'h13 : DW'($urandom);
            applyStimulus(1'b1, d, i == 0);
            checks++;
            if (win_valid !== exp_valid || win_last !== exp_last) begin
                errors++;
                $display("[TB] FAIL resync flags pix %0d: got valid=%b last=%b, want %b %b",
                         i, win_valid, win_last, exp_valid, exp_last);
            end
            if (exp_known) begin
                checks++;
                if (dut_win !== exp_win) begin
                    errors++;
                    $display("[TB] FAIL resync window pix %0d: got %h want %h", i, dut_win, exp_win);
                end
            end
            if (exp_valid && win_count == 1) begin
                checks++;
                if (m33 !== d || i != 2 * W + 2) begin
                    errors++;
                    $display("[TB] FAIL resync first window at pix %0d: got m33=%h want %h at pix %0d",
                             i, m33, d, 2 * W + 2);
                end
            end
        end
        checks++;
        if (dut_count !== 6) begin
            errors++;
            $display("[TB] FAIL resync window count: got %0d want 6", dut_count);
        end
    endtask

    task automatic test_reset_midframe();
        for (int i = 0; i < 2 * W + 2; i++)
            applyStimulus(1'b1, DW'(((i / W) * 16) + (i % W)), i == 0);
        applyReset(1);
        checks++;
        if (win_valid !== 1'b0 || win_last !== 1'b0 || dut_win !== 72'h0) begin
            errors++;
            $display("[TB] FAIL midframe reset: got valid=%b last=%b win=%h, want 0 0 0",
                     win_valid, win_last, dut_win);
        end
        win_count = 0;
        dut_count = 0;
        for (int i = 0; i < W * H; i++) begin
            logic [DW-1:0] d;
            d = DW'(((i / W) * 16) + (i % W));
            applyStimulus(1'b1, d, 1'b0);
            checks++;
            if (win_valid !== exp_valid || win_last !== exp_last) begin
                errors++;
                $display("[TB] FAIL post-reset flags pix %h: got valid=%b last=%b, want %b %b",
                         d, win_valid, win_last, exp_valid, exp_last);
            end
            if (exp_valid) begin
                checks++;
                if (dut_win !== exp_win) begin
                    errors++;
                    $display("[TB] FAIL post-reset window pix %h: got %h want %h", d, dut_win, exp_win);
                end
            end
            if (exp_valid && win_count == 1) begin
                checks++;
                if (dut_win !== 72'h00_01_02_10_11_12_20_21_22) begin
                    errors++;
                    $display("[TB] FAIL post-reset first window: got %h want 000102101112202122", dut_win);
                end
            end
        end
        checks++;
        if (dut_count !== 6) begin
            errors++;
            $display("[TB] FAIL post-reset window count: got %0d want 6", dut_count);
        end
    endtask

`ifdef LINE_WINDOW_SOF_ERR_EN
    task automatic test_sof_err();
        applyReset(1);
        checks++;
        if (err_short_frame !== 1'b0) begin
            errors++;
            $display("[TB] FAIL sof_err after reset: got %b want 0", err_short_frame);
        end
        for (int i = 0; i < 3 * W; i++)
            applyStimulus(1'b1, DW'(((i / W) * 16) + (i % W)), i == 0);
        checks++;
        if (err_short_frame !== 1'b0) begin
            errors++;
            $display("[TB] FAIL sof_err on clean sof: got %b want 0", err_short_frame);
        end
        for (int i = 0; i < 2 * W * H; i++) begin
            applyStimulus(1'b1, DW'($urandom), i == 0 || i == W * H);
            checks++;
            if (err_short_frame !== 1'b1) begin
                errors++;
                $display("[TB] FAIL sof_err sticky pix %0d: got %b want 1", i, err_short_frame);
            end
        end
        applyReset(1);
        checks++;
        if (err_short_frame !== 1'b0) begin
            errors++;
            $display("[TB] FAIL sof_err cleared by reset: got %b want 0", err_short_frame);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_continuous();
        test_gapped();
        test_random();
        test_sof_resync();
        test_reset_midframe();
`ifdef LINE_WINDOW_SOF_ERR_EN
        test_sof_err();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/line_window_3x3.md
Name: line_window_3x3

Overview:
- Upstream stage of the median-filter datapath.
- Accepts a raster-order 8-bit pixel stream and keeps two line buffers of history.
- Presents a 3x3 neighbourhood per accepted pixel, grouped as three rows of three pixels. Each row feeds one three-input sorter directly.
- Throughput is 1 pixel/clk. There is no backpressure.

Parameters:
IMG_WIDTH, 640, active pixels per line (>=3)
IMG_HEIGHT, 480, active lines per frame (>=3)
DATA_W, 8, pixel width

Ports:
clk  input  1  system clock
rst_n  input  1  synchronous active-low reset, sampled on rising edge of clk
pix_valid  input  1  qualifies pix_data/sof
pix_data  input  DATA_W  incoming pixel
sof  input  1  first pixel of frame; ignored unless pix_valid=1
win_valid  output  1  window outputs valid this cycle
win_last  output  1  with win_valid: final window of frame
m11,m12,m13  output  DATA_W each  top row (line r-2), columns c-2,c-1,c
m21,m22,m23  output  DATA_W each  middle row (line r-1); m22 is centre pixel
m31,m32,m33  output  DATA_W each  bottom row (line r); m33 is newest pixel

Behaviour:
- Accept: a pixel is accepted on any rising edge with rst_n=1 and pix_valid=1. All state changes only on accepts, except reset and clearing of win_valid/win_last.
- Counters:
  - col runs 0..IMG_WIDTH-1 and row runs 0..IMG_HEIGHT-1.
  - On each accept, col increments. At IMG_WIDTH-1, col wraps to 0 and row increments. At (IMG_HEIGHT-1, IMG_WIDTH-1), both wrap to 0.
  - The width of each counter is $clog2 of its limit.
- sof on an accept: the accepted pixel is treated as (row 0, col 0), then the counters step to col 1 as normal. This applies mid-frame too; that is the resync.
- Line buffers: two arrays lb1 and lb2, IMG_WIDTH deep, asynchronous read, read-before-write. On an accept at col c:
  - tap_top = lb2[c], tap_mid = lb1[c], tap_bot = pix_data.
  - Then lb2[c] <= lb1[c] and lb1[c] <= pix_data.
- Window:
  - On an accept, each row shifts left: mX1 <= mX2, mX2 <= mX3.
  - New column: m13 <= tap_top, m23 <= tap_mid, m33 <= tap_bot.
- win_valid:
  - Registered; asserted in the cycle after an accept whose (row, col) has row>=2 and col>=2, otherwise 0. Use the counter values before increment, with sof forcing (0,0).
  - Latency is 1 clk from the accepted pixel to its window. The window centre is pixel (row-1, col-1).
  - Windows at col 0/1 or row 0/1 are never flagged. They contain stale or cross-line data. There is no edge padding.
- win_last = win_valid for the accept at (IMG_HEIGHT-1, IMG_WIDTH-1).
- Window count per frame: (IMG_WIDTH-2)*(IMG_HEIGHT-2).
- Idle cycles (pix_valid=0): window registers hold, win_valid=0, win_last=0.
- Reset (rst_n=0, synchronous):
  - Counters, m11..m33, win_valid and win_last go to 0. Line-buffer contents are not reset.
  - Reset mid-frame aborts the frame. No win_valid is produced until two full lines have been accepted after reset.
  - The first line after reset is counted as row 0, even without sof.

Optional Feature:
- Macro: LINE_WINDOW_SOF_ERR_EN.
- Defined:
  - Adds output port err_short_frame (1 bit).
  - Set to 1 on an accept with sof=1 when the counters are not at (0,0), i.e. the previous frame was truncated.
  - Sticky until rst_n=0; reset value is 0.
- Undefined: no port, no logic. Mid-frame sof silently resyncs.

Decomposition:
- Shared package line_window_pkg: default IMG_WIDTH/IMG_HEIGHT/DATA_W constants and the window index constants (ROW_TOP/MID/BOT, COL_L/C/R) also used by the downstream median stage.
- One sub-module, line_buf: an IMG_WIDTH x DATA_W array with async read, synchronous write gated by wr_en, and read-before-write. Instantiated twice; the second is fed from the first's read data.

Test Plan:
Use IMG_WIDTH=5, IMG_HEIGHT=4, pixel value = row*16+col.
1. Hold rst_n=0 for 2 clk with random inputs -> all outputs 0, win_valid=0.
2. Continuous frame with sof on 0x00 -> first win_valid 1 clk after 0x22 accepted, with m11..m33 = 00,01,02,10,11,12,20,21,22. Exactly 6 windows. The last window ends at m33=0x34 with win_last=1.
3. Same frame with pix_valid toggling 1,0,0,1 -> identical 6 windows in the same order, each 1 clk after its accept, and win_valid=0 on idle cycles.
4. sof asserted on pixel 0x13 (row1, col3) -> counters resync. No win_valid until new-frame pixel (2,2). The next window has m33 = the pixel accepted at that point.
5. rst_n=0 for 1 clk during row 2 -> outputs 0 next cycle. Then a new frame -> exactly 6 windows, matching test 2.
6. With LINE_WINDOW_SOF_ERR_EN defined: sof at (3,0) -> err_short_frame=1 next cycle and held through later frames. rst_n=0 clears it to 0.
